sonata_mmcm_drp_model: RTL and testbench

// - Behavioural DRP responder standing in for the MMCME2_ADV in Icarus builds, so the clock DRP register path can be exercised end-to-end.
// - Holds a 128x16 DRP register space and answers DEN/DWE with DRDY after fixed latency.
// - Decodes the CLKOUT0 and CLKFBOUT dividers and models the LOCKED sequencing around RST/PWRDWN.

---
 rtl/sonata_mmcm_drp_model.sv | 217 +++++++++++++++++++++
 tb/tb_sonata_mmcm_drp_model.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sonata_mmcm_drp_model.sv
// -----------------------------------------------------------------------------
// sonata_mmcm_drp_model
//
// Behavioural stand-in for the MMCME2_ADV DRP port. Lets the clock DRP
// register path run end-to-end in simulators that have no MMCM primitive.
//
// - 128 x 16 DRP register space, answered with a one-cycle DRDY pulse a
//   fixed pLATENCY cycles after the accepted DEN.
// - CLKOUT0 divide (0x08/0x09) and CLKFBOUT multiply (0x14/0x15) are
//   decoded into registered outputs.
// - LOCKED drops while RST or PWRDWN is high and rises pLOCK_CYCLES cycles
//   after both are low.
//
// Ports
//   clk_usb      in   1   sole clock, doubles as DRP DCLK
//   reset_n      in   1   asynchronous active-low reset
//   drp_addr     in   7   DRP register address
//   drp_den      in   1   single-cycle transaction strobe
//   drp_dwe      in   1   write enable, sampled with drp_den
//   drp_din      in   16  write data, sampled with drp_den
//   drp_dout     out  16  read data, non-zero only while drp_drdy=1
//   drp_drdy     out  1   one-cycle completion pulse
//   drp_rst      in   1   MMCM RST
//   pwrdwn       in   1   MMCM PWRDWN
//   locked       out  1   MMCM LOCKED
//   clkout0_div  out  7   decoded CLKOUT0 divide
//   clkfb_mult   out  7   decoded CLKFBOUT multiply
//   proto_err    out  1   sticky protocol-violation flag
//
// Build option
//   DRP_ADDR_CHECK_EN  restrict the valid address map to 0x06-0x16,
//                      0x18-0x1A, 0x28, 0x4E-0x4F. Other addresses read 0,
//                      drop writes, still complete, and set proto_err.
// -----------------------------------------------------------------------------
module sonata_mmcm_drp_model #(
    parameter int unsigned pLATENCY     = 4,   // 1..15
    parameter int unsigned pLOCK_CYCLES = 64   // 1..65535
) (
    input  logic        clk_usb,
    input  logic        reset_n,
    input  logic [6:0]  drp_addr,
    input  logic        drp_den,
    input  logic        drp_dwe,
    input  logic [15:0] drp_din,
    output logic [15:0] drp_dout,
    output logic        drp_drdy,
    input  logic        drp_rst,
    input  logic        pwrdwn,
    output logic        locked,
    output logic [6:0]  clkout0_div,
    output logic [6:0]  clkfb_mult,
    output logic        proto_err
);

    localparam logic [3:0]  LAT_M1       = 4'(pLATENCY - 1);
    localparam bit          SINGLE_CYCLE = (pLATENCY == 1);
    localparam logic [15:0] LOCK_TGT     = 16'(pLOCK_CYCLES);

`ifdef DRP_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam logic [6:0]  A_CLKOUT0_1 = 7'h08;
    localparam logic [6:0]  A_CLKOUT0_2 = 7'h09;
    localparam logic [6:0]  A_CLKFB_1   = 7'h14;
    localparam logic [6:0]  A_CLKFB_2   = 7'h15;
    localparam logic [15:0] RST_CLKOUT0 = 16'h0186;  // HIGH=6,  LOW=6  -> 12
    localparam logic [15:0] RST_CLKFB   = 16'h0618;  // HIGH=24, LOW=24 -> 48

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic [6:0]  addr_q;
    logic        dwe_q;
    logic [15:0] din_q;
    logic [15:0] regs [128];
    logic [15:0] lock_cnt;

    function automatic logic addr_ok(input logic [6:0] a);
        logic in_map;
        in_map = (a >= 7'h06 && a <= 7'h16) || (a >= 7'h18 && a <= 7'h1A) ||
                 (a == 7'h28) || (a == 7'h4E) || (a == 7'h4F);
        return !ADDR_CHECK || in_map;
    endfunction

    // HIGH+LOW of zero means a full 64-count divider in the real MMCM.
    function automatic logic [6:0] decode_div(input logic [11:0] clk_reg1,
                                              input logic        no_count);
        logic [6:0] sum;
        sum = {1'b0, clk_reg1[11:6]} + {1'b0, clk_reg1[5:0]};
        if (no_count)
            return 7'd1;
        else if (sum == 7'd0)
            return 7'd64;
        else
            return sum;
    endfunction

    // A write commits on the edge that ends the DONE cycle.
    logic        wr_commit;
    logic [15:0] rd_fwd;      // read of drp_addr, seeing a write committing now
    logic [15:0] rd_held;     // read of the latched address
    logic [15:0] co0_r1_nx, fb_r1_nx;
    logic        co0_nc_nx, fb_nc_nx;
    logic [15:0] lock_cnt_nx;

    assign wr_commit = (state == DONE) && dwe_q && addr_ok(addr_q);

    // NOTE: every signal driven in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        rd_fwd = regs[drp_addr];
        if (wr_commit && addr_q == drp_addr)
            rd_fwd = din_q;
        if (!addr_ok(drp_addr))
            rd_fwd = '0;

        rd_held = addr_ok(addr_q) ? regs[addr_q] : 16'h0000;

        // Divider outputs follow the register contents including the write
        // committing on this edge, so they change the cycle after DONE.
        co0_r1_nx = (wr_commit && addr_q == A_CLKOUT0_1) ? din_q    : regs[A_CLKOUT0_1];
        co0_nc_nx = (wr_commit && addr_q == A_CLKOUT0_2) ? din_q[6] : regs[A_CLKOUT0_2][6];
        fb_r1_nx  = (wr_commit && addr_q == A_CLKFB_1)   ? din_q    : regs[A_CLKFB_1];
        fb_nc_nx  = (wr_commit && addr_q == A_CLKFB_2)   ? din_q[6] : regs[A_CLKFB_2][6];

        lock_cnt_nx = (lock_cnt == 16'hFFFF) ? lock_cnt : lock_cnt + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            addr_q      <= '0;
            dwe_q       <= 1'b0;
            din_q       <= '0;
            drp_dout    <= '0;
            drp_drdy    <= 1'b0;
            proto_err   <= 1'b0;
            lock_cnt    <= '0;
            locked      <= 1'b0;
            clkout0_div <= decode_div(RST_CLKOUT0[11:0], 1'b0);
            clkfb_mult  <= decode_div(RST_CLKFB[11:0], 1'b0);
            // NOTE: the register file is reset on purpose: the model must
            // come out of reset with the MMCM's documented defaults.
            for (int i = 0; i < 128; i++)
                regs[i] <= '0;
            regs[A_CLKOUT0_1] <= RST_CLKOUT0;
            regs[A_CLKFB_1]   <= RST_CLKFB;
        end else begin
            if (wr_commit)
                regs[addr_q] <= din_q;

            drp_drdy <= 1'b0;
            drp_dout <= '0;

            case (state)
                IDLE, DONE: begin
                    if (drp_den) begin
                        addr_q <= drp_addr;
                        dwe_q  <= drp_dwe;
                        din_q  <= drp_din;
                        count  <= LAT_M1;
                        if ((drp_dwe && !drp_rst) || !addr_ok(drp_addr))
                            proto_err <= 1'b1;
                        if (SINGLE_CYCLE) begin
                            state    <= DONE;
                            drp_drdy <= 1'b1;
                            drp_dout <= drp_dwe ? 16'h0000 : rd_fwd;
                        end else begin
                            state <= BUSY;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                BUSY: begin
                    // The port cannot queue requests; a strobe here is lost.
                    if (drp_den)
                        proto_err <= 1'b1;
                    if (count == 4'd1) begin
                        state    <= DONE;
                        drp_drdy <= 1'b1;
                        drp_dout <= dwe_q ? 16'h0000 : rd_held;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                default: state <= IDLE;
            endcase

            // Lock sequencing is independent of any DRP transaction.
            if (drp_rst || pwrdwn) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                lock_cnt <= lock_cnt_nx;
                locked   <= (lock_cnt_nx >= LOCK_TGT);
            end

            clkout0_div <= decode_div(co0_r1_nx[11:0], co0_nc_nx);
            clkfb_mult  <= decode_div(fb_r1_nx[11:0], fb_nc_nx);
        end
    end

endmodule

// File: tb/tb_sonata_mmcm_drp_model.sv
// -----------------------------------------------------------------------------
// tb_sonata_mmcm_drp_model
//
// Directed bench for sonata_mmcm_drp_model with default parameters
// (pLATENCY=4, pLOCK_CYCLES=64). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_sonata_mmcm_drp_model;

    logic        clk_usb = 1'b0;
    logic        reset_n;
    logic [6:0]  drp_addr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_din;
    logic [15:0] drp_dout;
    logic        drp_drdy;
    logic        drp_rst;
    logic        pwrdwn;
    logic        locked;
    logic [6:0]  clkout0_div;
    logic [6:0]  clkfb_mult;
    logic        proto_err;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    sonata_mmcm_drp_model dut (
        .clk_usb     (clk_usb),
        .reset_n     (reset_n),
        .drp_addr    (drp_addr),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_din     (drp_din),
        .drp_dout    (drp_dout),
        .drp_drdy    (drp_drdy),
        .drp_rst     (drp_rst),
        .pwrdwn      (pwrdwn),
        .locked      (locked),
        .clkout0_div (clkout0_div),
        .clkfb_mult  (clkfb_mult),
        .proto_err   (proto_err)
    );

    always #5 clk_usb = ~clk_usb;

    task automatic tick();
        @(posedge clk_usb);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One DRP transaction from a cycle where the port is free. Returns with
    // the bench sitting in the DRDY cycle; latency is bounded at 20 cycles.
    task automatic xfer(input string tag, input logic [6:0] a, input logic we,
                        input logic [15:0] d, output logic [15:0] rd);
        int lat;
        drp_addr = a;
        drp_dwe  = we;
        drp_din  = d;
        drp_den  = 1'b1;
        tick();
        drp_den = 1'b0;
        drp_dwe = 1'b0;
        lat = 1;
        while (!drp_drdy && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        rd = drp_dout;
    endtask

    // locked must still be low after 63 edges and high after the 64th.
    task automatic check_lock_exact(input string tag);
        repeat (63) tick();
        check({tag, " locked@63"}, 32'(locked), 32'd0);
        tick();
        check({tag, " locked@64"}, 32'(locked), 32'd1);
    endtask

    logic [15:0] rd;
    int          pulses;

    initial begin
        reset_n  = 1'b0;
        drp_addr = '0;
        drp_den  = 1'b0;
        drp_dwe  = 1'b0;
        drp_din  = '0;
        drp_rst  = 1'b0;
        pwrdwn   = 1'b0;
        repeat (3) tick();

        // ---- reset state ----
        check("rst drdy",   32'(drp_drdy),    32'd0);
        check("rst dout",   32'(drp_dout),    32'd0);
        check("rst locked", 32'(locked),      32'd0);
        check("rst perr",   32'(proto_err),   32'd0);
        check("rst div",    32'(clkout0_div), 32'd12);
        check("rst mult",   32'(clkfb_mult),  32'd48);

        // ---- lock after reset release, default reads ----
        reset_n = 1'b1;
        check_lock_exact("post-reset");
        xfer("rd 08", 7'h08, 1'b0, 16'h0, rd);
        check("rd 08 data", 32'(rd), 32'h0186);
        tick();
        xfer("rd 14", 7'h14, 1'b0, 16'h0, rd);
        check("rd 14 data", 32'(rd), 32'h0618);
        tick();
        check("reads perr", 32'(proto_err), 32'd0);

        // ---- write 0x08 while RST held ----
        drp_rst = 1'b1;
        tick();
        check("rst forces unlock", 32'(locked), 32'd0);
        drp_addr = 7'h08;
        drp_dwe  = 1'b1;
        drp_din  = 16'h0145;
        drp_den  = 1'b1;
        tick();
        drp_den = 1'b0;
        drp_dwe = 1'b0;
        check("wr08 drdy@1", 32'(drp_drdy), 32'd0);
        tick();
        tick();
        check("wr08 drdy@3", 32'(drp_drdy), 32'd0);
        tick();
        check("wr08 drdy@4", 32'(drp_drdy), 32'd1);
        check("wr08 dout",   32'(drp_dout), 32'd0);
        check("wr08 div old", 32'(clkout0_div), 32'd12);
        tick();
        check("wr08 drdy@5", 32'(drp_drdy), 32'd0);
        check("wr08 div new", 32'(clkout0_div), 32'd10);
        xfer("rb 08", 7'h08, 1'b0, 16'h0, rd);
        check("rb 08 data", 32'(rd), 32'h0145);
        check("wr08 perr",  32'(proto_err), 32'd0);
        tick();
        drp_rst = 1'b0;
        check_lock_exact("rst release");

        // ---- write with RST low while locked ----
        xfer("wr 14", 7'h14, 1'b1, 16'h0208, rd);
        check("wr14 perr", 32'(proto_err), 32'd1);
        tick();
        check("wr14 mult", 32'(clkfb_mult), 32'd16);
        xfer("rb 14", 7'h14, 1'b0, 16'h0, rd);
        check("rb 14 data", 32'(rd), 32'h0208);
        tick();
        check("locked before pwrdwn", 32'(locked), 32'd1);
        pwrdwn = 1'b1;
        tick();
        check("pwrdwn unlock", 32'(locked), 32'd0);
        pwrdwn = 1'b0;
        check_lock_exact("pwrdwn release");

        // ---- NO_COUNT bypass ----
        xfer("wr 09", 7'h09, 1'b1, 16'h0040, rd);
        tick();
        check("nocount div", 32'(clkout0_div), 32'd1);

        // ---- back-to-back DEN in the DONE cycle ----
        xfer("b2b wr 7f", 7'h7F, 1'b1, 16'hBEEF, rd);
        drp_addr = 7'h7F;
        drp_den  = 1'b1;
        tick();
        drp_den = 1'b0;
        check("b2b drdy@1", 32'(drp_drdy), 32'd0);
        tick();
        tick();
        check("b2b drdy@3", 32'(drp_drdy), 32'd0);
        tick();
        check("b2b drdy@4", 32'(drp_drdy), 32'd1);
`ifdef DRP_ADDR_CHECK_EN
        check("b2b rd 7f", 32'(drp_dout), 32'h0000);
`else
        check("b2b rd 7f", 32'(drp_dout), 32'hBEEF);
`endif
        tick();

        // ---- reset_n mid-BUSY aborts the transaction ----
        drp_addr = 7'h08;
        drp_den  = 1'b1;
        tick();
        drp_den = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("abort drdy in reset", 32'(drp_drdy), 32'd0);
        tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (drp_drdy) pulses++;
        end
        check("abort drdy count", 32'(pulses), 32'd0);
        check("abort perr",   32'(proto_err),   32'd0);
        check("abort div",    32'(clkout0_div), 32'd12);
        check("abort mult",   32'(clkfb_mult),  32'd48);
        check("abort locked", 32'(locked),      32'd0);
        xfer("def 08", 7'h08, 1'b0, 16'h0, rd);
        check("def 08 data", 32'(rd), 32'h0186);
        tick();
        xfer("def 09", 7'h09, 1'b0, 16'h0, rd);
        check("def 09 data", 32'(rd), 32'h0000);
        tick();

        // ---- DEN while BUSY is ignored and flagged ----
        check("busy perr before", 32'(proto_err), 32'd0);
        drp_addr = 7'h14;
        drp_den  = 1'b1;
        tick();
        drp_den = 1'b0;
        tick();
        drp_den = 1'b1;
        tick();
        drp_den = 1'b0;
        check("busy drdy@3", 32'(drp_drdy), 32'd0);
        check("busy perr",   32'(proto_err), 32'd1);
        tick();
        check("busy drdy@4", 32'(drp_drdy), 32'd1);
        check("busy rd 14",  32'(drp_dout), 32'h0618);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (drp_drdy) pulses++;
        end
        check("busy extra drdy", 32'(pulses), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
